// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet PHY management logic.
// Holds the manager state encoding, PHY register addresses and the init write contents.
package ethernet_pkg;

    typedef enum logic [2:0] {
        StHold   = 3'd0,
        StSettle = 3'd1,
        StIssue  = 3'd2,
        StWait   = 3'd3,
        StIdle   = 3'd4
    } state_e;

    localparam logic [4:0] PHY_BMCR = 5'd0;
    localparam logic [4:0] PHY_ANAR = 5'd4;

    // Advertise 10/100 full and half duplex; enable and restart autonegotiation.
    localparam logic [15:0] ANAR_INIT = 16'h01E1;
    localparam logic [15:0] BMCR_INIT = 16'h1200;

    localparam int unsigned IDX_W = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } smi_write_t;

endpackage

// File: rtl/phy_init_rom.sv
// Combinational PHY init table: maps an entry index to the SMI write it issues.
// Editing the table here leaves the sequencing FSM untouched.
module phy_init_rom
    import ethernet_pkg::*;
(
    input  logic [IDX_W-1:0] index_i,
    output smi_write_t       entry_o
);

    always_comb begin
        entry_o = '0;
        case (index_i)
            4'd0:    entry_o = '{addr: PHY_ANAR, data: ANAR_INIT};
            4'd1:    entry_o = '{addr: PHY_BMCR, data: BMCR_INIT};
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/phy_manager.sv
// Ethernet PHY bring-up and runtime SMI arbitration: holds the PHY in reset, waits to settle,
// plays the init table through the SMI unit, then serves host register writes.
module phy_manager
    import ethernet_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 2500,
    parameter int unsigned SETTLE_CYCLES = 2500,
    parameter int unsigned TIMEOUT       = 4095,
    parameter int unsigned NUM_INIT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ethernet_reset,
    output logic        smi_init,
    output logic [4:0]  smi_register,
    output logic [15:0] smi_content,
    input  logic        smi_ready,
    input  logic        host_req,
    input  logic [4:0]  host_register,
    input  logic [15:0] host_content,
    output logic        host_ack,
    output logic        host_busy,
    output logic        config_done,
    output logic        config_error
);

    localparam bit ParamsOk = (RESET_CYCLES >= 1) && (RESET_CYCLES <= 16383) &&
                              (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 16384) &&
                              (TIMEOUT >= 1) && (TIMEOUT <= 4095) &&
                              (NUM_INIT >= 1) && (NUM_INIT < (1 << IDX_W));

    // The PHY reset releases on the edge RESET_CYCLES after the first edge out of reset.
    localparam logic [13:0]      HoldLast   = 14'(RESET_CYCLES);
    localparam logic [13:0]      SettleLast = 14'(SETTLE_CYCLES - 1);
    localparam logic [11:0]      TmoLimit   = 12'(TIMEOUT);
    localparam logic [IDX_W-1:0] NumInit    = IDX_W'(NUM_INIT);

    state_e           state_q, state_d;
    logic [13:0]      cnt_q, cnt_d;
    logic [11:0]      tmo_q, tmo_d, tmo_next;
    logic [IDX_W-1:0] idx_q, idx_d, idx_next;
    logic             saw_busy_q, saw_busy_d;
    logic [4:0]       host_reg_q, host_reg_d;
    logic [15:0]      host_data_q, host_data_d;
    logic             eth_rst_q, eth_rst_d;
    logic             smi_init_q, smi_init_d;
    logic [4:0]       smi_reg_q, smi_reg_d;
    logic [15:0]      smi_data_q, smi_data_d;
    logic             host_ack_q, host_ack_d;
    logic             host_busy_q, host_busy_d;
    logic             config_done_q, config_done_d;
    logic             config_error_q, config_error_d;
    logic             complete, abort;
    smi_write_t       rom_entry;

    phy_init_rom u_rom (
        .index_i (idx_q),
        .entry_o (rom_entry)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        idx_d          = idx_q;
        saw_busy_d     = saw_busy_q;
        host_reg_d     = host_reg_q;
        host_data_d    = host_data_q;
        smi_init_d     = 1'b0;
        smi_reg_d      = smi_reg_q;
        smi_data_d     = smi_data_q;
        host_ack_d     = 1'b0;
        config_done_d  = config_done_q;
        config_error_d = config_error_q;
        tmo_next       = tmo_q + 12'd1;
        idx_next       = idx_q + IDX_W'(1);
        complete       = smi_ready && saw_busy_q;
        abort          = !complete && (tmo_next == TmoLimit);

        unique case (state_q)
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            StIssue: begin
                if (smi_ready) begin
                    smi_init_d = 1'b1;
                    if (config_done_q) begin
                        smi_reg_d  = host_reg_q;
                        smi_data_d = host_data_q;
                    end else begin
                        smi_reg_d  = rom_entry.addr;
                        smi_data_d = rom_entry.data;
                    end
                    saw_busy_d = 1'b0;
                    tmo_d      = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                saw_busy_d = saw_busy_q | ~smi_ready;
                tmo_d      = tmo_next;
                if (complete || abort) begin
                    if (abort) begin
                        config_error_d = 1'b1;
                    end
                    if (!config_done_q) begin
                        idx_d = idx_next;
                        if (idx_next == NumInit) begin
                            config_done_d = 1'b1;
                            state_d       = StIdle;
                        end else begin
                            state_d = StIssue;
                        end
                    end else begin
                        host_ack_d = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StIdle: begin
                // The ack cycle still belongs to the request that just finished.
                if (host_req && !host_ack_q) begin
                    host_reg_d  = host_register;
                    host_data_d = host_content;
                    state_d     = StIssue;
                end
            end
            default: state_d = StHold;
        endcase

        eth_rst_d   = (state_d != StHold);
        host_busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StHold;
            cnt_q          <= '0;
            tmo_q          <= '0;
            idx_q          <= '0;
            saw_busy_q     <= 1'b0;
            host_reg_q     <= '0;
            host_data_q    <= '0;
            eth_rst_q      <= 1'b0;
            smi_init_q     <= 1'b0;
            smi_reg_q      <= '0;
            smi_data_q     <= '0;
            host_ack_q     <= 1'b0;
            host_busy_q    <= 1'b1;
            config_done_q  <= 1'b0;
            config_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            idx_q          <= idx_d;
            saw_busy_q     <= saw_busy_d;
            host_reg_q     <= host_reg_d;
            host_data_q    <= host_data_d;
            eth_rst_q      <= eth_rst_d;
            smi_init_q     <= smi_init_d;
            smi_reg_q      <= smi_reg_d;
            smi_data_q     <= smi_data_d;
            host_ack_q     <= host_ack_d;
            host_busy_q    <= host_busy_d;
            config_done_q  <= config_done_d;
            config_error_q <= config_error_d;
        end
    end

    always_ff @(posedge clk) begin
        assert (ParamsOk);
    end

    assign ethernet_reset = eth_rst_q;
    assign smi_init       = smi_init_q;
    assign smi_register   = smi_reg_q;
    assign smi_content    = smi_data_q;
    assign host_ack       = host_ack_q;
    assign host_busy      = host_busy_q;
    assign config_done    = config_done_q;
    assign config_error   = config_error_q;

endmodule
